rv32_fetch_queue: RTL and testbench

Parametrised next-generation fetch stage for the rv32 core. It owns the fetch PC and issues sequential instruction-memory requests. Returned instructions are buffered with their PC in a DEPTH-entry FIFO, and {pc, instr} pairs are handed to decode over a valid/ready handshake. Adds decode back-pressure, prefetch buffering and PC redirect (branch/jump flush), which the single-entry fetch buffer lacks.

---
 rtl/rv32_fetch_queue.sv | 85 ++++++++
 tb/tb_rv32_fetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_fetch_queue.sv
// Fetch stage for the rv32 core: owns the fetch PC, issues sequential requests,
// and buffers returned {pc, instr} pairs in a DEPTH-entry FIFO toward decode.
module rv32_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int         CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    output logic [31:0]   instr_addr,
    output logic          instr_req,
    input  logic [31:0]   instr_bus,
    input  logic          instr_ready,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          fetch_valid,
    input  logic          fetch_ready,
    output logic [31:0]   fetch_instr,
    output logic [31:0]   fetch_pc,
    output logic [CW-1:0] queue_count,
    output logic          queue_full
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]   next_pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic          pop;
    logic          push;
    logic          space;

    // A redirect hides the head so decode never consumes a wrong-path entry.
    assign fetch_valid = (count != '0) & ~redirect_valid;
    assign pop         = fetch_valid & fetch_ready;
    assign space       = (count < CW'(DEPTH)) | pop;
    assign instr_req   = space & ~redirect_valid & resetn;
    assign push        = instr_req & instr_ready;

    assign instr_addr  = next_pc;
    assign fetch_instr = mem_instr[head];
    assign fetch_pc    = mem_pc[head];
    assign queue_count = count;
    assign queue_full  = (count == CW'(DEPTH));

    // NOTE: storage is deliberately left out of reset; entries are only read
    // once count says they were written, and resetting them only costs area.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail]    <= next_pc;
            mem_instr[tail] <= instr_bus;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            next_pc <= RESET_PC;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else if (redirect_valid) begin
            next_pc <= redirect_pc & 32'hFFFF_FFFC;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tail    <= tail + PW'(1);
                next_pc <= next_pc + 32'd4;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_fetch_queue.sv
// Directed bench for rv32_fetch_queue: a cycle model with a {pc, instr}
// scoreboard checks every output each cycle, plus targeted boundary checks.
module tb_rv32_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CW       = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic [31:0]   instr_addr;
    logic          instr_req;
    logic [31:0]   instr_bus;
    logic          instr_ready;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          fetch_valid;
    logic          fetch_ready;
    logic [31:0]   fetch_instr;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] queue_count;
    logic          queue_full;

    int            checks   = 0;
    int            failures = 0;
    entry_t        sb[$];
    logic [31:0]   popped[$];
    logic [31:0]   m_pc;

    rv32_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .instr_addr     (instr_addr),
        .instr_req      (instr_req),
        .instr_bus      (instr_bus),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .queue_count    (queue_count),
        .queue_full     (queue_full)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hC0DE_0013;
    endfunction

    // Memory model: every word is tagged by its own address.
    always_comb instr_bus = instr_ready ? word_of(instr_addr) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare all outputs against the model at the negedge,
    // then advance the model on the posedge.
    task automatic cycle();
        logic m_valid, m_pop, m_req, m_push;
        entry_t e;
        @(negedge clk);
        m_valid = (sb.size() != 0) && !redirect_valid;
        m_pop   = m_valid && fetch_ready;
        m_req   = ((sb.size() < DEPTH) || m_pop) && !redirect_valid;
        m_push  = m_req && instr_ready;
        check("instr_req",   32'(instr_req),   32'(m_req));
        check("instr_addr",  instr_addr,       m_pc);
        check("fetch_valid", 32'(fetch_valid), 32'(m_valid));
        check("queue_count", 32'(queue_count), 32'(sb.size()));
        check("queue_full",  32'(queue_full),  32'(sb.size() == DEPTH));
        if (m_valid) begin
            check("fetch_pc",    fetch_pc,    sb[0].pc);
            check("fetch_instr", fetch_instr, sb[0].instr);
        end
        @(posedge clk);
        if (redirect_valid) begin
            sb.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (m_pop) begin
                e = sb.pop_front();
                popped.push_back(e.pc);
            end
            if (m_push) begin
                e.pc    = m_pc;
                e.instr = word_of(m_pc);
                sb.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        resetn         = 1'b0;
        instr_ready    = 1'b0;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        m_pc           = RESET_PC;

        // Reset state
        #3;
        check("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        check("rst_queue_count", 32'(queue_count), 32'h0);
        check("rst_queue_full",  32'(queue_full),  32'h0);
        check("rst_instr_req",   32'(instr_req),   32'h0);
        check("rst_instr_addr",  instr_addr,       RESET_PC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // 1: streaming, one instruction per cycle
        instr_ready = 1'b1;
        fetch_ready = 1'b1;
        repeat (10) cycle();
        check("t1_pop_count", 32'(popped.size()), 32'd9);
        for (int i = 0; i < popped.size(); i++) check("t1_pop_pc", popped[i], 32'(4 * i));
        check("t1_queue_count", 32'(queue_count), 32'd1);

        // 2: decode back-pressure fills the queue, then drains in order
        redirect(32'h0);
        popped.delete();
        fetch_ready = 1'b0;
        repeat (6) cycle();
        check("t2_full",       32'(queue_full),  32'h1);
        check("t2_count",      32'(queue_count), 32'd4);
        check("t2_req_off",    32'(instr_req),   32'h0);
        check("t2_addr_hold",  instr_addr,       32'd16);
        fetch_ready = 1'b1;
        repeat (5) cycle();
        check("t2_pop_count", 32'(popped.size()), 32'd5);
        for (int i = 0; i < popped.size(); i++) check("t2_pop_pc", popped[i], 32'(4 * i));

        // 3: full queue with simultaneous push+pop across pointer wrap
        repeat (10) cycle();
        check("t3_count", 32'(queue_count), 32'd4);
        check("t3_pop_count", 32'(popped.size()), 32'd15);
        for (int i = 0; i < popped.size(); i++) check("t3_pop_pc", popped[i], 32'(4 * i));

        // 4: redirect flushes a partly filled queue
        redirect(32'h200);
        fetch_ready = 1'b0;
        repeat (3) cycle();
        check("t4_count_pre", 32'(queue_count), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1002;
        fetch_ready    = 1'b1;
        #1;
        check("t4_valid_masked", 32'(fetch_valid), 32'h0);
        check("t4_req_masked",   32'(instr_req),   32'h0);
        cycle();
        redirect_valid = 1'b0;
        check("t4_count_post", 32'(queue_count), 32'd0);
        check("t4_addr_post",  instr_addr,       32'h0000_1000);
        popped.delete();
        for (int i = 0; i < 10 && popped.size() == 0; i++) cycle();
        check("t4_first_pop", (popped.size() != 0) ? popped[0] : 32'hFFFF_FFFF, 32'h0000_1000);
        // back-to-back redirects: the last one wins
        redirect(32'h3000);
        redirect(32'h4004);
        check("t4_b2b_addr", instr_addr, 32'h0000_4004);

        // 5: memory stalls hold the address without skipping or repeating
        popped.delete();
        for (int r = 0; r < 3; r++) begin
            instr_ready = 1'b1; cycle();
            instr_ready = 1'b0; cycle();
            cycle();
            instr_ready = 1'b1; cycle();
        end
        check("t5_pop_count", 32'(popped.size()), 32'd5);
        for (int i = 0; i < popped.size(); i++) check("t5_pop_pc", popped[i], 32'h4004 + 32'(4 * i));

        // 6: PC wraps past the top of the address space
        redirect(32'hFFFF_FFF8);
        popped.delete();
        repeat (4) cycle();
        check("t6_pop_count", 32'(popped.size()), 32'd3);
        check("t6_pop0", (popped.size() > 0) ? popped[0] : 32'h1, 32'hFFFF_FFF8);
        check("t6_pop1", (popped.size() > 1) ? popped[1] : 32'h1, 32'hFFFF_FFFC);
        check("t6_pop2", (popped.size() > 2) ? popped[2] : 32'h1, 32'h0000_0000);
        fetch_ready = 1'b0;
        repeat (2) cycle();
        check("t6_count_pre_rst", 32'(queue_count), 32'd3);

        // Asynchronous reset mid-stream, away from any clock edge
        #2;
        resetn = 1'b0;
        #1;
        check("arst_fetch_valid", 32'(fetch_valid), 32'h0);
        check("arst_queue_count", 32'(queue_count), 32'h0);
        check("arst_queue_full",  32'(queue_full),  32'h0);
        check("arst_instr_req",   32'(instr_req),   32'h0);
        check("arst_instr_addr",  instr_addr,       RESET_PC);
        sb.delete();
        m_pc        = RESET_PC;
        instr_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        fetch_ready = 1'b1;
        popped.delete();
        repeat (4) cycle();
        check("post_rst_first_pop", (popped.size() != 0) ? popped[0] : 32'hFFFF_FFFF, RESET_PC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
